// File: rtl/au_addsub_seq.sv
// au_addsub_seq: multi-word add/subtract sequencer that reuses one WIDTH-bit au_addsub_c,
// least-significant word first, with a registered carry and valid/ready on both sides.

// au_addsub_c: WIDTH-bit adder/subtractor, {co,s} = a + (add_sub ? ~b : b) + ci.
module au_addsub_c #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             add_sub,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  logic [WIDTH-1:0] bx;
  assign bx = b ^ {WIDTH{add_sub}};
  generate
    if (ARCH == 0) begin : g_ripple
      logic [WIDTH:0] c;
      assign c[0] = ci;
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign s[i]   = a[i] ^ bx[i] ^ c[i];
        assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
      end
      assign co = c[WIDTH];
    end else begin : g_behav
      assign {co, s} = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(ci);
    end
  endgenerate
endmodule

module au_addsub_seq #(
  parameter int WIDTH = 8,
  parameter int NWORD = 4,
  parameter int ARCH  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*NWORD-1:0] a,
  input  logic [WIDTH*NWORD-1:0] b,
  input  logic                   ci,
  input  logic                   add_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*NWORD-1:0] s,
  output logic                   co,
  output logic                   busy
);
  localparam int W  = WIDTH * NWORD;
  localparam int IW = NWORD > 1 ? $clog2(NWORD) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0]    idx;
  logic [W-1:0]     a_q, b_q, s_q;
  logic             sub_q, cr, co_q, last;
  logic [WIDTH-1:0] aw, bw, sw;
  logic             cw;
  assign last = idx == IW'(NWORD - 1);
  // Word select for the shared adder; idx never exceeds NWORD-1.
  always_comb begin
    aw = '0;
    bw = '0;
    for (int k = 0; k < NWORD; k++)
      if (idx == IW'(k)) begin
        aw = a_q[k*WIDTH +: WIDTH];
        bw = b_q[k*WIDTH +: WIDTH];
      end
  end
  au_addsub_c #(.WIDTH(WIDTH), .ARCH(ARCH)) u_add (
    .a(aw), .b(bw), .ci(cr), .add_sub(sub_q), .s(sw), .co(cw)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n   = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
    if (state == IDLE && in_valid) state_n = RUN;
    if (state == RUN && last) state_n = DONE;
    if (state == DONE && out_ready) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx   <= '0;
      cr    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sub_q <= 1'b0;
      s_q   <= '0;
      co_q  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_q   <= a;
      b_q   <= b;
      sub_q <= add_sub;
      cr    <= ci;
      idx   <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < NWORD; k++)
        if (idx == IW'(k)) s_q[k*WIDTH +: WIDTH] <= sw;
      cr <= cw;
      if (last) co_q <= cw;
      else idx <= idx + IW'(1);
    end
  assign s  = s_q;
  assign co = co_q;
endmodule

// File: tb/tb_au_addsub_seq.sv
// tb_au_addsub_seq: directed table vectors, back-pressure, async reset and a short
// random sweep on NWORD=4 and NWORD=1 instances against a full-width reference.
module tb_au_addsub_seq;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, ci = 0, add_sub = 0, out_ready = 0;
  logic [31:0] a = 0, b = 0;
  logic        in_ready, out_valid, co, busy;
  logic [31:0] s;
  logic        in_valid1 = 0, out_ready1 = 0;
  logic        in_ready1, out_valid1, co1, busy1;
  logic [7:0]  s1;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  au_addsub_seq #(.WIDTH(8), .NWORD(4), .ARCH(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .add_sub(add_sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .co(co), .busy(busy)
  );

  au_addsub_seq #(.WIDTH(8), .NWORD(1), .ARCH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a[7:0]), .b(b[7:0]), .ci(ci), .add_sub(add_sub), .out_valid(out_valid1),
    .out_ready(out_ready1), .s(s1), .co(co1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] a, b;
    logic        ci, sub;
    logic [31:0] s;
    logic        co;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic op4(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                     input logic tsub, input int stall, input logic [31:0] es,
                     input logic eco, input string nm);
    int n;
    @(negedge clk);
    a = ta; b = tb; ci = tci; add_sub = tsub; in_valid = 1;
    chk({nm, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 0; a = $urandom; b = $urandom; ci = ~ci; add_sub = ~add_sub;
    n = 0;
    while (!out_valid && n < 20) begin
      if (!busy) chk({nm, " busy"}, 64'(busy), 64'd1);
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd4);
    chk({nm, " s"}, 64'(s), 64'(es));
    chk({nm, " co"}, 64'(co), 64'(eco));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom); a = $urandom; b = $urandom;
      @(posedge clk); #1;
      chk({nm, " stall hold"}, {29'd0, out_valid, in_ready, co, s}, {29'd0, 1'b1, 1'b0, eco, es});
    end
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({nm, " release"}, {30'd0, out_valid, in_ready, s}, {30'd0, 1'b0, 1'b1, es});
  endtask

  task automatic op1(input logic [7:0] ta, input logic [7:0] tb, input logic tci,
                     input logic tsub, input string nm);
    logic [8:0] r;
    int n;
    r = {1'b0, ta} + {1'b0, tsub ? ~tb : tb} + 9'(tci);
    @(negedge clk);
    a = {24'd0, ta}; b = {24'd0, tb}; ci = tci; add_sub = tsub; in_valid1 = 1;
    @(posedge clk); #1;
    in_valid1 = 0; a = $urandom; b = $urandom;
    n = 0;
    while (!out_valid1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd1);
    chk({nm, " result"}, {55'd0, co1, s1}, {55'd0, r});
    out_ready1 = 1;
    @(posedge clk); #1;
    out_ready1 = 0;
  endtask

  initial begin
    vec_t tv[7];
    logic [32:0] r;
    logic [31:0] ra, rb;
    logic        rc, rs;
    tv[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0};
    tv[1] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1};
    tv[2] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1};
    tv[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0};
    tv[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1};
    tv[5] = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0};
    tv[6] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0};
    #12;
    chk("reset state", {28'd0, in_ready, out_valid, busy, co, s},
        {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 7; i++) op4(tv[i].a, tv[i].b, tv[i].ci, tv[i].sub, 0, tv[i].s, tv[i].co, $sformatf("vec%0d", i));
    op4(32'h0000ABCD, 32'h00001111, 1'b0, 1'b0, 5, 32'h0000BCDE, 1'b0, "backpressure");
    op4(32'h00000100, 32'h00000001, 1'b1, 1'b1, 0, 32'h000000FF, 1'b1, "after stall");
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01010101; ci = 1; add_sub = 0; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 0; #1;
    chk("async reset", {28'd0, in_ready, out_valid, busy, co, s},
        {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
    @(negedge clk); rst_n = 1;
    op4(32'h12345678, 32'h11111111, 1'b0, 1'b0, 0, 32'h23456789, 1'b0, "post reset");
    for (int i = 0; i < 200; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
      r = {1'b0, ra} + {1'b0, rs ? ~rb : rb} + 33'(rc);
      op4(ra, rb, rc, rs, int'($urandom_range(0, 2)), r[31:0], r[32], $sformatf("rand4_%0d", i));
    end
    op1(8'hFF, 8'h01, 1'b0, 1'b0, "n1 add wrap");
    op1(8'h05, 8'h07, 1'b1, 1'b1, "n1 sub borrow");
    for (int i = 0; i < 100; i++) op1(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand1_%0d", i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
